// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared types and constants for the UDP/IPv4/Ethernet transmitter.
// Optional build macro: UDP_TX_MIN_PAD_EN adds the PAD state to the FSM encoding.
package udp_tx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHKSUM,
        ST_PREAMBLE,
        ST_ETH_HDR,
        ST_IP_HDR,
        ST_UDP_HDR,
        ST_PAYLOAD,
`ifdef UDP_TX_MIN_PAD_EN
        ST_PAD,
`endif
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [7:0]  IP_TTL        = 8'h40;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [15:0] HDR_OVERHEAD  = 16'd28;
    localparam logic [15:0] IP_HDR_LEN    = 16'd20;
    localparam logic [15:0] ETH_HDR_LEN   = 16'd14;
    localparam logic [15:0] MIN_FRAME     = 16'd60;

    // Two carry folds are enough: ten 16-bit words never exceed 20 bits.
    function automatic logic [15:0] csum_fold(input logic [31:0] sum);
        logic [16:0] t;
        t = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
        return ~(t[15:0] + {15'd0, t[16]});
    endfunction

endpackage

// File: rtl/udp_tx_crc32.sv
// crc32_d8: byte-wide reflected CRC32 (IEEE) next-state logic plus its register.
module crc32_d8
    import udp_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);

    logic [31:0] r_crc;
    logic [31:0] w_next;

    // Eight LSB-first shift steps of the reflected polynomial for one byte.
    always_comb begin
        w_next = r_crc ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            w_next = w_next[0] ? ((w_next >> 1) ^ CRC_POLY) : (w_next >> 1);
        end
    end

    // CRC accumulator: cleared before each frame, advanced on covered bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC_INIT;
        end else if (clr) begin
            r_crc <= CRC_INIT;
        end else if (en) begin
            r_crc <= w_next;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/udp_tx.sv
// udp_tx: builds an Ethernet II / IPv4 / UDP frame and drives GMII TX.
// Optional build macro: UDP_TX_MIN_PAD_EN pads short frames to 60 bytes before FCS.
module udp_tx
    import udp_tx_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = 32'hC0A8_0164,
    parameter logic [15:0] SRC_PORT   = 16'd1234,
    parameter logic [15:0] DES_PORT   = 16'd1234,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        gmii_clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [15:0] ip_data_len,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    input  logic [7:0]  tx_data,
    output logic        tx_req,
    output logic        busy,
    output logic        tx_done,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd
);

    tx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_ip_len;
    logic [47:0] r_des_mac;
    logic [31:0] r_des_ip;
    logic [15:0] r_ip_id;
    logic [31:0] r_sum;
    logic [15:0] r_ip_csum;
    logic        r_tx_req;
    logic        r_busy;
    logic        r_tx_done;
    logic        r_tx_en;
    logic [7:0]  r_txd;

    logic [15:0]       w_pay_len;
    logic [15:0]       w_udp_len;
    logic [31:0]       w_sum;
    logic [13:0][7:0]  w_eth;
    logic [19:0][7:0]  w_ip;
    logic [7:0][7:0]   w_udp;
    logic [3:0][7:0]   w_fcs;
    logic [31:0]       w_crc;
    logic [7:0]        w_byte;
    logic              w_en;
    logic              w_crc_en;
    logic              w_crc_clr;
`ifdef UDP_TX_MIN_PAD_EN
    logic [15:0]       w_pad_len;
    assign w_pad_len = MIN_FRAME - ETH_HDR_LEN - r_ip_len;
`endif

    assign w_pay_len = r_ip_len - HDR_OVERHEAD;
    assign w_udp_len = r_ip_len - IP_HDR_LEN;
    assign w_eth     = {r_des_mac, BOARD_MAC, ETH_TYPE_IPV4};
    assign w_ip      = {8'h45, 8'h00, r_ip_len, r_ip_id, 16'h4000, IP_TTL, IP_PROTO_UDP,
                        r_ip_csum, BOARD_IP, r_des_ip};
    assign w_udp     = {SRC_PORT, DES_PORT, w_udp_len, 16'h0000};
    assign w_fcs     = ~w_crc;
    assign w_crc_clr = (r_state == ST_CHKSUM);
    assign w_sum     = 32'h4500 + {16'd0, r_ip_len} + {16'd0, r_ip_id} + 32'h4000
                     + {16'd0, IP_TTL, IP_PROTO_UDP}
                     + {16'd0, BOARD_IP[31:16]} + {16'd0, BOARD_IP[15:0]}
                     + {16'd0, r_des_ip[31:16]} + {16'd0, r_des_ip[15:0]};

    // Select the byte the GMII register loads next and whether the CRC covers it.
    always_comb begin
        w_byte   = '0;
        w_en     = 1'b0;
        w_crc_en = 1'b0;
        unique case (r_state)
            ST_PREAMBLE: begin
                w_en   = 1'b1;
                w_byte = (r_cnt == 16'd7) ? SFD_BYTE : PREAMBLE_BYTE;
            end
            ST_ETH_HDR: begin
                w_en     = 1'b1;
                w_crc_en = 1'b1;
                w_byte   = w_eth[4'd13 - r_cnt[3:0]];
            end
            ST_IP_HDR: begin
                w_en     = 1'b1;
                w_crc_en = 1'b1;
                w_byte   = w_ip[5'd19 - r_cnt[4:0]];
            end
            ST_UDP_HDR: begin
                w_en     = 1'b1;
                w_crc_en = 1'b1;
                w_byte   = w_udp[3'd7 - r_cnt[2:0]];
            end
            ST_PAYLOAD: begin
                w_en     = 1'b1;
                w_crc_en = 1'b1;
                w_byte   = tx_data;
            end
`ifdef UDP_TX_MIN_PAD_EN
            ST_PAD: begin
                w_en     = 1'b1;
                w_crc_en = 1'b1;
            end
`endif
            ST_FCS: begin
                w_en   = 1'b1;
                w_byte = w_fcs[r_cnt[1:0]];
            end
            default: ;
        endcase
    end

    // Frame sequencer with registered GMII, request, busy and done outputs.
    // tx_req is issued one state ahead so upstream data lands exactly when the
    // payload byte is loaded, keeping payload contiguous with the UDP header.
    always_ff @(posedge gmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ip_len  <= '0;
            r_des_mac <= '0;
            r_des_ip  <= '0;
            r_ip_id   <= '0;
            r_sum     <= '0;
            r_ip_csum <= '0;
            r_tx_req  <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx_en   <= 1'b0;
            r_txd     <= '0;
        end else begin
            r_txd     <= w_byte;
            r_tx_en   <= w_en;
            r_tx_done <= 1'b0;
            r_tx_req  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (tx_start && (ip_data_len >= HDR_OVERHEAD + 16'd1)) begin
                        r_ip_len  <= ip_data_len;
                        r_des_mac <= des_mac;
                        r_des_ip  <= des_ip;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_CHKSUM;
                    end
                end
                ST_CHKSUM: begin
                    if (r_cnt == 16'd0) begin
                        r_sum <= w_sum;
                        r_cnt <= 16'd1;
                    end else begin
                        r_ip_csum <= csum_fold(r_sum);
                        r_cnt     <= '0;
                        r_state   <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (r_cnt == 16'd7) begin
                        r_cnt   <= '0;
                        r_state <= ST_ETH_HDR;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_ETH_HDR: begin
                    if (r_cnt == 16'd13) begin
                        r_cnt   <= '0;
                        r_state <= ST_IP_HDR;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_IP_HDR: begin
                    if (r_cnt == 16'd19) begin
                        r_cnt   <= '0;
                        r_state <= ST_UDP_HDR;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_UDP_HDR: begin
                    if (r_cnt == 16'd6) begin
                        r_tx_req <= 1'b1;
                    end
                    if (r_cnt == 16'd7) begin
                        r_tx_req <= (w_pay_len > 16'd1);
                        r_cnt    <= '0;
                        r_state  <= ST_PAYLOAD;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_PAYLOAD: begin
                    r_tx_req <= (r_cnt + 16'd2 < w_pay_len);
                    if (r_cnt == w_pay_len - 16'd1) begin
                        r_cnt <= '0;
`ifdef UDP_TX_MIN_PAD_EN
                        r_state <= (r_ip_len < MIN_FRAME - ETH_HDR_LEN) ? ST_PAD : ST_FCS;
`else
                        r_state <= ST_FCS;
`endif
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`ifdef UDP_TX_MIN_PAD_EN
                ST_PAD: begin
                    if (r_cnt == w_pad_len - 16'd1) begin
                        r_cnt   <= '0;
                        r_state <= ST_FCS;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`endif
                ST_FCS: begin
                    if (r_cnt == 16'd3) begin
                        r_tx_done <= 1'b1;
                        r_ip_id   <= r_ip_id + 16'd1;
                        r_cnt     <= '0;
                        r_state   <= ST_IFG;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_IFG: begin
                    if (r_cnt == 16'(IFG_CYCLES - 1)) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    crc32_d8 u_crc (
        .clk   (gmii_clk),
        .rst_n (rst_n),
        .clr   (w_crc_clr),
        .en    (w_crc_en),
        .d     (w_byte),
        .crc   (w_crc)
    );

    assign tx_req     = r_tx_req;
    assign busy       = r_busy;
    assign tx_done    = r_tx_done;
    assign gmii_tx_en = r_tx_en;
    assign gmii_txd   = r_txd;

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: directed self-checking bench for udp_tx.
module tb_udp_tx;

    logic        gmii_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [15:0] ip_data_len = '0;
    logic [47:0] des_mac = 48'hA1A2_A3A4_A5A6;
    logic [31:0] des_ip = 32'hC0A8_010A;
    logic [7:0]  tx_data = '0;
    logic        tx_req, busy, tx_done, gmii_tx_en;
    logic [7:0]  gmii_txd;

    localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;

    int tests = 0;
    int fails = 0;
    int frames = 0;
    int req_cycles = 0;
    int done_pulses = 0;
    int r0, d0, f0;
    logic prev_en = 1'b0;
    logic [7:0] cur[$];
    logic [7:0] last_frame[$];
    logic [7:0] exp_q[$];
    logic [15:0] pay_idx = '0;

    udp_tx #(
        .BOARD_MAC  (MAC),
        .BOARD_IP   (32'hC0A8_0164),
        .SRC_PORT   (16'd1234),
        .DES_PORT   (16'd1234),
        .IFG_CYCLES (12)
    ) dut (
        .gmii_clk    (gmii_clk),
        .rst_n       (rst_n),
        .tx_start    (tx_start),
        .ip_data_len (ip_data_len),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .busy        (busy),
        .tx_done     (tx_done),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd)
    );

    always #4 gmii_clk = ~gmii_clk;

    // Upstream source: incrementing payload, one cycle after each request.
    always @(posedge gmii_clk) begin
        if (!busy) begin
            pay_idx <= '0;
        end else if (tx_req) begin
            tx_data <= pay_idx[7:0];
            pay_idx <= pay_idx + 16'd1;
        end
    end

    // Wire monitor: collects each gmii_tx_en burst as one frame.
    always @(negedge gmii_clk) begin
        if (gmii_tx_en) cur.push_back(gmii_txd);
        if (prev_en && !gmii_tx_en) begin
            last_frame = cur;
            cur = {};
            frames++;
        end
        if (tx_req) req_cycles++;
        if (tx_done) done_pulses++;
        prev_en = gmii_tx_en;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [15:0] len);
        @(negedge gmii_clk);
        ip_data_len = len;
        tx_start = 1'b1;
        @(negedge gmii_clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (frames < target && n < 2000) begin
            @(negedge gmii_clk);
            n++;
        end
        @(negedge gmii_clk);
        chk({tag, "_timeout"}, 64'(frames >= target), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge gmii_clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // Reference frame: preamble through FCS, built from field definitions.
    task automatic build_exp(input logic [15:0] len, input logic [15:0] id);
        logic [7:0]  ip[20];
        logic [31:0] s, crc;
        logic [15:0] c, ul;
        int n;
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) exp_q.push_back(des_mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(MAC[8*i +: 8]);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        ip = '{8'h45, 8'h00, len[15:8], len[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
               8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h64,
               des_ip[31:24], des_ip[23:16], des_ip[15:8], des_ip[7:0]};
        s = '0;
        for (int i = 0; i < 20; i += 2) s += {16'd0, ip[i], ip[i+1]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        c = ~s[15:0];
        ip[10] = c[15:8];
        ip[11] = c[7:0];
        for (int i = 0; i < 20; i++) exp_q.push_back(ip[i]);
        ul = len - 16'd20;
        exp_q.push_back(8'h04); exp_q.push_back(8'hD2);
        exp_q.push_back(8'h04); exp_q.push_back(8'hD2);
        exp_q.push_back(ul[15:8]); exp_q.push_back(ul[7:0]);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        n = int'(len) - 28;
        for (int k = 0; k < n; k++) exp_q.push_back(8'(k));
`ifdef UDP_TX_MIN_PAD_EN
        while (exp_q.size() < 68) exp_q.push_back(8'h00);
`endif
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < exp_q.size(); i++) begin
            crc ^= {24'd0, exp_q[i]};
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
    endtask

    task automatic cmp_frame(input string tag);
        int nbad = 0;
        chk({tag, "_len"}, 64'(last_frame.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < last_frame.size(); i++) begin
            if (last_frame[i] !== exp_q[i]) nbad++;
        end
        chk({tag, "_bytes_differing"}, 64'(nbad), 0);
    endtask

    function automatic logic [31:0] tail_word(input logic [7:0] q[$]);
        int n = q.size();
        if (n < 4) return '0;
        return {q[n-1], q[n-2], q[n-3], q[n-4]};
    endfunction

    function automatic logic [15:0] rx_ip_sum();
        logic [31:0] s = '0;
        for (int i = 0; i < 10; i++) s += {16'd0, last_frame[22+2*i], last_frame[23+2*i]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return s[15:0];
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge gmii_clk);
        chk("reset_outputs", {tx_req, busy, tx_done, gmii_tx_en, gmii_txd}, 0);
        rst_n = 1'b1;

        // Frame 1: 141-byte IP datagram, 113-byte payload
        r0 = req_cycles; d0 = done_pulses; f0 = frames;
        start_frame(16'd141);
        wait_frames(f0 + 1, "f1");
        chk("f1_req_cycles", 64'(req_cycles - r0), 113);
        chk("f1_done_pulses", 64'(done_pulses - d0), 1);
        chk("f1_en_cycles", 64'(last_frame.size()), 167);
        chk("f1_udp_len", {last_frame[46], last_frame[47]}, 16'h0079);
        chk("f1_ip_id", {last_frame[26], last_frame[27]}, 16'h0000);
        chk("f1_ip_csum", {last_frame[32], last_frame[33]}, 16'hB6A1);
        chk("f1_ip_ones_sum", rx_ip_sum(), 16'hFFFF);
        build_exp(16'd141, 16'h0000);
        cmp_frame("f1");
        chk("f1_fcs", tail_word(last_frame), tail_word(exp_q));

        // Frame 2: identification advances
        wait_idle();
        f0 = frames;
        start_frame(16'd141);
        wait_frames(f0 + 1, "f2");
        chk("f2_ip_id", {last_frame[26], last_frame[27]}, 16'h0001);
        chk("f2_ip_csum", {last_frame[32], last_frame[33]}, 16'hB6A0);
        build_exp(16'd141, 16'h0001);
        cmp_frame("f2");

        // Frame 3: start pulses mid-frame and during IFG are ignored
        wait_idle();
        f0 = frames;
        start_frame(16'd141);
        repeat (40) @(negedge gmii_clk);
        chk("f3_busy_mid", busy, 1);
        tx_start = 1'b1;
        @(negedge gmii_clk);
        tx_start = 1'b0;
        wait_frames(f0 + 1, "f3");
        build_exp(16'd141, 16'h0002);
        cmp_frame("f3");
        repeat (3) @(negedge gmii_clk);
        chk("f3_busy_in_ifg", busy, 1);
        tx_start = 1'b1;
        @(negedge gmii_clk);
        tx_start = 1'b0;
        wait_idle();
        repeat (5) @(negedge gmii_clk);
        chk("f3_no_extra_frame", 64'(frames), 64'(f0 + 1));
        chk("f3_en_idle", gmii_tx_en, 0);

        // Frame 4: first preamble byte three edges after the accepting edge
        @(negedge gmii_clk);
        ip_data_len = 16'd141;
        tx_start = 1'b1;
        @(posedge gmii_clk);
        #1 tx_start = 1'b0;
        @(posedge gmii_clk);
        @(posedge gmii_clk);
        #1 chk("f4_en_in_chksum", gmii_tx_en, 0);
        @(posedge gmii_clk);
        #1 chk("f4_first_byte", {gmii_tx_en, gmii_txd}, {1'b1, 8'h55});
        wait_frames(f0 + 2, "f4");
        build_exp(16'd141, 16'h0003);
        cmp_frame("f4");

        // Length boundary: 28 rejected, 29 gives a one-byte payload
        wait_idle();
        f0 = frames;
        start_frame(16'd28);
        chk("len28_busy", busy, 0);
        repeat (20) @(negedge gmii_clk);
        chk("len28_no_frame", {64'(frames), busy, gmii_tx_en}, {64'(f0), 2'b00});
        start_frame(16'd29);
        wait_frames(f0 + 1, "len29");
        chk("len29_wire_bytes", 64'(last_frame.size()), 55);
        build_exp(16'd29, 16'h0004);
        cmp_frame("len29");

        // Short frame: padded to 60 bytes before FCS only with the pad option
        wait_idle();
        f0 = frames;
        start_frame(16'd30);
        wait_frames(f0 + 1, "len30");
`ifdef UDP_TX_MIN_PAD_EN
        chk("len30_wire_bytes", 64'(last_frame.size()), 72);
`else
        chk("len30_wire_bytes", 64'(last_frame.size()), 56);
`endif
        build_exp(16'd30, 16'h0005);
        cmp_frame("len30");
        chk("len30_fcs", tail_word(last_frame), tail_word(exp_q));

        // Reset in the middle of the payload
        wait_idle();
        start_frame(16'd141);
        for (int n = 0; n < 200 && !tx_req; n++) @(negedge gmii_clk);
        chk("rst_req_seen", tx_req, 1);
        repeat (5) @(negedge gmii_clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outputs", {gmii_tx_en, tx_req, busy}, 3'b000);
        @(negedge gmii_clk);
        rst_n = 1'b1;
        @(negedge gmii_clk);
        @(negedge gmii_clk);
        chk("rst_idle", busy, 0);
        f0 = frames;
        start_frame(16'd141);
        wait_frames(f0 + 1, "rst_next");
        chk("rst_next_ip_id", {last_frame[26], last_frame[27]}, 16'h0000);
        build_exp(16'd141, 16'h0000);
        cmp_frame("rst_next");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
